// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared widths and queue entry type for the fetch front end
package inst_fetch_queue_pkg;

  localparam int FETCH_INST_WIDTH   = 32;
  localparam int PKG_INST_MEM_WIDTH = 15;

  typedef struct packed {
    logic [FETCH_INST_WIDTH-1:0]   inst;
    logic [PKG_INST_MEM_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_if.sv
// rtl/inst_fetch_queue_if.sv - control, memory and decode handshake bundle of the fetch front end
interface inst_fetch_queue_if #(
  parameter int AW = inst_fetch_queue_pkg::PKG_INST_MEM_WIDTH
);
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          input_start;
  logic          input_end;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   inst;
  logic [AW-1:0] pc_out;
  logic [AW-1:0] pc1_out;
  logic          inst_enable;

  modport master (
    input  redirect, redirect_pc, input_start, input_end, mem_rdata, out_ready,
    output mem_rd_en, mem_addr, out_valid, inst, pc_out, pc1_out, inst_enable
  );

  modport slave (
    output redirect, redirect_pc, input_start, input_end, mem_rdata, out_ready,
    input  mem_rd_en, mem_addr, out_valid, inst, pc_out, pc1_out, inst_enable
  );
endinterface

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// rtl/inst_fetch_queue_fetch_fifo.sv - prefetch FIFO with flush, head view and occupancy count
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 47
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // A full queue still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - sequential instruction fetch with latency-tracking tag pipe and prefetch queue
// Define INST_FETCH_STALL_CNT_EN to add the stall_cycles counter port.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int INST_MEM_WIDTH = PKG_INST_MEM_WIDTH,
  parameter int MEM_LATENCY    = 3,
  parameter int QUEUE_DEPTH    = 4
) (
  input  logic               CLK,
  input  logic               reset,
  inst_fetch_queue_if.master bus
`ifdef INST_FETCH_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cycles
`endif
);
  typedef logic [INST_MEM_WIDTH-1:0] pc_t;

  pc_t                         fetch_pc_q, fetch_pc_d;
  logic                        inst_enable_q, inst_enable_d;
  logic [MEM_LATENCY-1:0]      tag_vld_q, tag_vld_d;
  pc_t                         tag_pc_q [MEM_LATENCY];
  logic [$clog2(QUEUE_DEPTH):0] count;
  fetch_entry_t                push_entry, head;
  logic                        issue, push, pop, out_valid;
  int                          credits_used;

  assign out_valid = (count != '0);
  assign pop       = out_valid && bus.out_ready;
  assign push      = tag_vld_q[MEM_LATENCY-1] && !bus.redirect;

  // Credits count queued plus in-flight words; the departing head frees its slot at once
  always_comb begin
    credits_used = int'(count) - int'(pop) + $countones(tag_vld_q);
    issue        = !reset && inst_enable_q && !bus.redirect && (credits_used < QUEUE_DEPTH);
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.redirect)  fetch_pc_d = bus.redirect_pc;
    else if (issue)    fetch_pc_d = fetch_pc_q + INST_MEM_WIDTH'(1);

    inst_enable_d = inst_enable_q;
    if (bus.input_start)    inst_enable_d = 1'b0;
    else if (bus.input_end) inst_enable_d = 1'b1;

    tag_vld_d = '0;
    for (int i = MEM_LATENCY - 1; i > 0; i--) tag_vld_d[i] = tag_vld_q[i-1];
    tag_vld_d[0] = issue;
    if (bus.redirect) tag_vld_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      fetch_pc_q    <= '0;
      inst_enable_q <= 1'b1;
      tag_vld_q     <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) tag_pc_q[i] <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inst_enable_q <= inst_enable_d;
      tag_vld_q     <= tag_vld_d;
      tag_pc_q[0]   <= fetch_pc_q;
      for (int i = 1; i < MEM_LATENCY; i++) tag_pc_q[i] <= tag_pc_q[i-1];
    end
  end

  assign push_entry = '{inst: bus.mem_rdata, pc: tag_pc_q[MEM_LATENCY-1]};

  fetch_fifo #(
    .DEPTH (QUEUE_DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fetch_fifo (
    .clk_i   (CLK),
    .rst_i   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign bus.mem_rd_en   = issue;
  assign bus.mem_addr    = fetch_pc_q;
  assign bus.out_valid   = out_valid;
  assign bus.inst        = head.inst;
  assign bus.pc_out      = head.pc;
  assign bus.pc1_out     = head.pc + INST_MEM_WIDTH'(1);
  assign bus.inst_enable = inst_enable_q;

`ifdef INST_FETCH_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.out_ready && !out_valid && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cycles = stall_cnt_q;
`endif
endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - scoreboard bench for inst_fetch_queue with latency-modelled instruction memory
module tb_inst_fetch_queue;
  localparam int AW = 15;
  localparam int L  = 3;
  localparam int D  = 4;

  logic CLK = 1'b0;
  logic reset;
  always #5 CLK = ~CLK;

  inst_fetch_queue_if #(.AW(AW)) bus();
`ifdef INST_FETCH_STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  inst_fetch_queue #(
    .INST_MEM_WIDTH (AW),
    .MEM_LATENCY    (L),
    .QUEUE_DEPTH    (D)
  ) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
`ifdef INST_FETCH_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int pops = 0;
  int issues = 0;
  int t0, r, g, p0, i0;
  logic en_model = 1'b1;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] addr_pipe [L];

  always @(posedge CLK) cyc <= cyc + 1;

  // Instruction memory: word at address a is a + 0x100, returned L cycles after the strobe
  always @(posedge CLK) begin
    addr_pipe[0] <= bus.mem_addr;
    for (int i = 1; i < L; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign bus.mem_rdata = 32'(addr_pipe[L-1]) + 32'h100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected fetch stream restarts at each redirect or reset target
  task automatic refill(input logic [AW-1:0] target);
    exp_q.delete();
    for (int i = 0; i < 512; i++) exp_q.push_back(target + AW'(i));
  endtask

  task automatic tick();
    @(posedge CLK);
    if (reset) begin
      refill('0);
      en_model = 1'b1;
    end else begin
      if (bus.redirect) refill(bus.redirect_pc);
      if (bus.input_start)    en_model = 1'b0;
      else if (bus.input_end) en_model = 1'b1;
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.redirect = 1'b0;
    bus.input_start = 1'b0;
    bus.input_end = 1'b0;
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_inst", bus.inst, 0);
    check("rst_pc_out", bus.pc_out, 0);
    check("rst_pc1_out", bus.pc1_out, 1);
    check("rst_inst_enable", bus.inst_enable, 1);
    check("rst_mem_rd_en", bus.mem_rd_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    tick();
    reset = 1'b0;
    t0 = cyc;
  endtask

  always @(negedge CLK) begin
    logic [AW-1:0] e, e1;
    if (reset === 1'b0) begin
      if (bus.out_valid && bus.out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL pop_unexpected: got pc 0x%0h expected no entry", bus.pc_out);
        end else begin
          e = exp_q.pop_front();
          e1 = e + 1'b1;
          check("pop_pc", bus.pc_out, e);
          check("pop_inst", bus.inst, 32'(e) + 32'h100);
          check("pop_pc1", bus.pc1_out, e1);
        end
      end
      if (bus.mem_rd_en) issues++;
      check("inst_enable", bus.inst_enable, en_model);
      if (!(en_model && !bus.redirect)) check("issue_gated", bus.mem_rd_en, 0);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    bus.redirect = 1'b0;
    bus.redirect_pc = '0;
    bus.input_start = 1'b0;
    bus.input_end = 1'b0;
    bus.out_ready = 1'b1;

    // Clean start with decode always ready
    do_reset();
    @(negedge CLK);
    check("c0_mem_rd_en", bus.mem_rd_en, 1);
    check("c0_mem_addr", bus.mem_addr, 0);
    g = 0;
    while (!bus.out_valid && g < 20) begin
      @(negedge CLK);
      g++;
    end
    check("first_valid_cycle", cyc - t0, L + 1);
    check("first_inst", bus.inst, 32'h100);
    check("first_pc1", bus.pc1_out, 1);
`ifdef INST_FETCH_STALL_CNT_EN
    check("stall_cycles", stall_cycles, 4);
`endif
    tick();
    p0 = pops;
    repeat (20) tick();
    check("stream_rate", pops - p0, 20);

    // Backpressure from reset: only D reads may be outstanding
    bus.out_ready = 1'b0;
    do_reset();
    i0 = issues;
    repeat (20) tick();
    check("bp_issues", issues - i0, D);
    check("bp_valid", bus.out_valid, 1);
    check("bp_head_pc", bus.pc_out, 0);
    bus.out_ready = 1'b1;
    repeat (16) tick();

    // Redirect with reads in flight
    bus.redirect = 1'b1;
    bus.redirect_pc = 15'h40;
    r = cyc;
    tick();
    bus.redirect = 1'b0;
    check("redir_flushed", bus.out_valid, 0);
    g = 0;
    while (!bus.out_valid && g < 20) begin
      tick();
      g++;
    end
    check("redir_latency", cyc - r, L + 2);
    check("redir_head_pc", bus.pc_out, 15'h40);
    repeat (10) tick();

    // PC wrap at the top of the address space
    bus.redirect = 1'b1;
    bus.redirect_pc = 15'h7FFF;
    tick();
    bus.redirect = 1'b0;
    g = 0;
    while (!bus.out_valid && g < 20) begin
      tick();
      g++;
    end
    check("wrap_head_pc", bus.pc_out, 15'h7FFF);
    check("wrap_head_pc1", bus.pc1_out, 0);
    repeat (15) tick();

    // I/O phase gating
    bus.input_start = 1'b1;
    tick();
    bus.input_start = 1'b0;
    check("io_disabled", bus.inst_enable, 0);
    i0 = issues;
    p0 = pops;
    repeat (10) tick();
    check("io_no_issue", issues - i0, 0);
    check("io_drain", pops - p0, D);
    bus.input_end = 1'b1;
    tick();
    bus.input_end = 1'b0;
    check("io_enabled", bus.inst_enable, 1);
    repeat (10) tick();
    bus.input_start = 1'b1;
    bus.input_end = 1'b1;
    tick();
    bus.input_start = 1'b0;
    bus.input_end = 1'b0;
    check("io_both_start_wins", bus.inst_enable, 0);
    bus.input_end = 1'b1;
    tick();
    bus.input_end = 1'b0;

    // Randomised traffic
    for (int k = 0; k < 400; k++) begin
      if (k == 200) begin
        do_reset();
      end else begin
        bus.out_ready = ($urandom_range(0, 9) < 7);
        bus.redirect = ($urandom_range(0, 99) < 4);
        bus.redirect_pc = ($urandom_range(0, 3) == 0) ? 15'h7FFE : AW'($urandom_range(0, 32767));
        bus.input_start = ($urandom_range(0, 99) < 3);
        bus.input_end = ($urandom_range(0, 99) < 6);
        tick();
      end
    end
    bus.redirect = 1'b0;
    bus.input_start = 1'b0;
    bus.input_end = 1'b1;
    bus.out_ready = 1'b1;
    tick();
    bus.input_end = 1'b0;
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Parametrised instruction-fetch front end: issues sequential reads to an external instruction memory of fixed read latency, tracks in-flight reads, and buffers returned words in a prefetch queue drained by the decode stage with a valid/ready handshake. It supports redirect (branch/jump) with flush of queued and in-flight fetches and keeps the I/O-phase fetch gating (`inst_enable`). It sits between the PC/branch logic and decode, replacing the fixed four-cycle fetch stage.

## Interface
- `INST_MEM_WIDTH`, 15, PC / instruction-memory address width
- `MEM_LATENCY`, 3, cycles from `mem_rd_en` to valid `mem_rdata` (≥1)
- `QUEUE_DEPTH`, 4, prefetch-queue entries (power of two, ≥2)
- `CLK` in 1: single clock, all logic on posedge
- `reset` in 1: synchronous, active-high
- `redirect` in 1: load new fetch PC and flush
- `redirect_pc` in INST_MEM_WIDTH: target PC
- `input_start` in 1: begin I/O phase, stop issuing
- `input_end` in 1: end I/O phase, resume issuing
- `mem_rd_en` out 1: read strobe to instruction memory
- `mem_addr` out INST_MEM_WIDTH: read address
- `mem_rdata` in 32: read data, valid MEM_LATENCY cycles after strobe
- `out_valid` out 1: queue head valid
- `out_ready` in 1: decode accepts head
- `inst` out 32: head instruction
- `pc_out` out INST_MEM_WIDTH: head PC
- `pc1_out` out INST_MEM_WIDTH: head PC+1 (mod 2^INST_MEM_WIDTH)
- `inst_enable` out 1: fetch permitted (not in I/O phase)
- `stall_cycles` out 32: present only with `INST_FETCH_STALL_CNT_EN`

## Operation
- Reset values: `fetch_pc`=0, queue empty, tag pipe cleared, `mem_rd_en`=0, `mem_addr`=0, `out_valid`=0, `inst`=0, `pc_out`=0, `pc1_out`=1, `inst_enable`=1, `stall_cycles`=0. Reset mid-operation discards all queued and in-flight fetches.
- Issue: `mem_rd_en`=1 when `inst_enable` && !`redirect` && (occupancy + in-flight) < QUEUE_DEPTH; `mem_addr`=`fetch_pc`; `fetch_pc` increments, wrapping at 2^INST_MEM_WIDTH−1 → 0.
- Tag pipe: MEM_LATENCY-stage shift register of {valid, pc}; stage 0 loaded on issue. When the last stage is valid, `mem_rdata` and its pc are pushed into the queue.
- Credit rule guarantees no overflow; push and pop in the same cycle are legal at any occupancy, including full.
- Pop: `out_valid` && `out_ready`. `out_valid` = queue non-empty; `inst`/`pc_out`/`pc1_out` show head entry, hold when not popped.
- Redirect: `fetch_pc` ← `redirect_pc`; queue emptied; all tag-pipe valid bits cleared, so returning stale data is dropped; no issue and no push that cycle. A pop handshaking in the redirect cycle completes with the old head. First issue to `redirect_pc` is the following cycle.
- `inst_enable`: `input_start` clears, `input_end` sets, `input_start` wins if both. While 0 no new issue; in-flight reads still land and the queue drains normally. `redirect` while disabled updates `fetch_pc`.

## Timing
- Cycle 0 = first cycle with `reset` low: issue of pc 0. The data is pushed at cycle MEM_LATENCY, with `out_valid`=1 at cycle MEM_LATENCY+1.
- Redirect at cycle r: issue of the target at r+1, `out_valid` at r+MEM_LATENCY+2.
- Sustained throughput is 1 instr/cycle when QUEUE_DEPTH ≥ MEM_LATENCY+1; otherwise issue is limited to QUEUE_DEPTH per MEM_LATENCY+1 cycles.
- All outputs are registered or decoded from registered state; there is no combinational path from `out_ready` or `redirect` to `out_valid`.

## Configuration
- `INST_FETCH_STALL_CNT_EN` defined: `stall_cycles` increments (saturating at 2^32−1) each cycle where `out_ready`=1 and `out_valid`=0 and `reset`=0.
- Not defined: the port and counter are absent.

## Structure
- A shared package holds `FETCH_INST_WIDTH`=32 and a typedef `fetch_entry_t` {inst[31:0], pc}. The package takes the pc width from the package-level constant matching INST_MEM_WIDTH.
- There is one sub-module, `fetch_fifo`: parametrised depth/width FIFO with push/pop/flush, head outputs, and a count output used for credit calculation.

## Test plan
- Reset then `out_ready`=1, MEM_LATENCY=3, memory returns addr+0x100: `out_valid` first at cycle 4 with `inst`=0x100, `pc_out`=0, `pc1_out`=1, then one entry per cycle with consecutive PCs.
- `out_ready`=0 for 20 cycles: exactly QUEUE_DEPTH=4 reads are issued and the queue holds pcs 0–3. Raising `out_ready` drains them in order, then streaming resumes at pc 4.
- `redirect`=1, `redirect_pc`=0x40 while 3 reads are in flight: no stale words appear, and the first popped entry has `pc_out`=0x40.
- `fetch_pc`=0x7FFF with INST_MEM_WIDTH=15: the entries popped have pc 0x7FFF then 0x0000; the head with pc 0x7FFF shows `pc1_out`=0.
- `input_start` pulse during streaming: `inst_enable`=0 next cycle and issue stops while in-flight words still arrive. `input_end` restores issue from the next PC; with both asserted, `inst_enable`=0.
- With `INST_FETCH_STALL_CNT_EN`: `out_ready` is held high from reset and the clean start is at cycle 0. The bubble covers cycles 0–3 while `out_valid` is low, so `stall_cycles`=4.
